// File: rtl/int_ctrl.sv
// int_ctrl: 4-line rising-edge interrupt controller, fixed priority (line 0 highest), maskable, vectored.
// Define IC_NESTING_EN to let a higher-priority line preempt a line already in service.
module int_ctrl #(
  parameter logic [9:0] VEC_BASE   = 10'd1000,
  parameter logic [9:0] VEC_STRIDE = 10'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] int_in,
  input  logic       mask_we,
  input  logic [3:0] mask_din,
  input  logic       irq_ack,
  input  logic       iret,
  output logic       irq,
  output logic [9:0] vector,
  output logic [3:0] pending,
  output logic [3:0] in_service,
  output logic [3:0] mask
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t     state;
  logic [3:0] int_q;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] isr_low;
  logic [1:0] id;
  logic [1:0] elig_id;
  logic       take;

  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [9:0] vec_of(input logic [1:0] n);
    return VEC_BASE + VEC_STRIDE * {8'd0, n};
  endfunction

  assign rise     = int_in & ~int_q;
  assign eligible = pending & ~mask;
  assign elig_id  = first_set(eligible);
  // Highest-priority (lowest-index) bit currently in service.
  assign isr_low  = in_service & (~in_service + 4'd1);

`ifdef IC_NESTING_EN
  logic [1:0] isr_id;
  assign isr_id = first_set(in_service);
`endif

  always_comb begin
    take = 1'b0;
    if (eligible != 4'd0) begin
      if (state == IDLE) take = 1'b1;
`ifdef IC_NESTING_EN
      // A return in the same cycle is handled first; preemption is re-evaluated next cycle.
      else if (state == SERV && !iret && elig_id < isr_id) take = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      vector     <= 10'd0;
      id         <= 2'd0;
      pending    <= 4'd0;
      in_service <= 4'd0;
      mask       <= 4'b1111;
      int_q      <= 4'd0;
    end else begin
      int_q   <= int_in;
      pending <= pending | rise;
      if (mask_we) mask <= mask_din;

      if (take) begin
        id     <= elig_id;
        vector <= vec_of(elig_id);
        irq    <= 1'b1;
        state  <= REQ;
      end else begin
        case (state)
          REQ: begin
            if (irq_ack) begin
              // A fresh edge on the acknowledged line re-arms it.
              pending    <= (pending & ~(4'b0001 << id)) | rise;
              in_service <= in_service | (4'b0001 << id);
              irq        <= 1'b0;
              state      <= SERV;
            end
          end
          SERV: begin
            if (iret) begin
              in_service <= in_service & ~isr_low;
              if ((in_service & ~isr_low) == 4'd0) state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; expectations follow IC_NESTING_EN when defined.
module tb_int_ctrl;
  logic       clk;
  logic       reset;
  logic [3:0] int_in;
  logic       mask_we;
  logic [3:0] mask_din;
  logic       irq_ack;
  logic       iret;
  logic       irq;
  logic [9:0] vector;
  logic [3:0] pending;
  logic [3:0] in_service;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .clk(clk), .reset(reset), .int_in(int_in), .mask_we(mask_we), .mask_din(mask_din),
    .irq_ack(irq_ack), .iret(iret), .irq(irq), .vector(vector), .pending(pending),
    .in_service(in_service), .mask(mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_din = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; int_in = 4'd0; mask_we = 1'b0; mask_din = 4'd0; irq_ack = 1'b0; iret = 1'b0;
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq); end
    checks++; if (vector !== 10'd0) begin errors++; $display("FAIL rst_vector: got %0d exp 0", vector); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b exp 0000", pending); end
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL rst_in_service: got %b exp 0000", in_service); end
    checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL rst_mask: got %b exp 1111", mask); end
    reset = 1'b0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_release_irq: got %b exp 0", irq); end
  endtask

  task automatic test_basic;
    set_mask(4'b0000);
    checks++; if (mask !== 4'b0000) begin errors++; $display("FAIL basic_mask: got %b exp 0000", mask); end
    int_in = 4'b0100;
    tick();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL basic_pending: got %b exp 0100", pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_early: got %b exp 0", irq); end
    int_in = 4'b0000;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b exp 1", irq); end
    checks++; if (vector !== 10'd1008) begin errors++; $display("FAIL basic_vector: got %0d exp 1008", vector); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_ack_irq: got %b exp 0", irq); end
    checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL basic_in_service: got %b exp 0100", in_service); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL basic_ack_pending: got %b exp 0000", pending); end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL basic_iret: got %b exp 0000", in_service); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_idle_irq: got %b exp 0", irq); end
  endtask

  task automatic test_priority;
    int_in = 4'b1010;
    tick();
    int_in = 4'b0000;
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending: got %b exp 1010", pending); end
    tick();
    checks++; if (vector !== 10'd1004) begin errors++; $display("FAIL prio_vector1: got %0d exp 1004", vector); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (in_service !== 4'b0010) begin errors++; $display("FAIL prio_in_service: got %b exp 0010", in_service); end
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_left: got %b exp 1000", pending); end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq2: got %b exp 1", irq); end
    checks++; if (vector !== 10'd1012) begin errors++; $display("FAIL prio_vector2: got %0d exp 1012", vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL prio_done: got %b exp 0000", in_service); end
  endtask

  task automatic test_mask;
    set_mask(4'b0001);
    int_in = 4'b0001;
    tick();
    int_in = 4'b0000;
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pending: got %b exp 0001", pending); end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_held_irq: got %b exp 0", irq); end
    set_mask(4'b0000);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_load_irq: got %b exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_unmask_irq: got %b exp 1", irq); end
    checks++; if (vector !== 10'd1000) begin errors++; $display("FAIL mask_vector: got %0d exp 1000", vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (in_service !== 4'b0001) begin errors++; $display("FAIL mask_in_service: got %b exp 0001", in_service); end
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  task automatic test_stable;
    int_in = 4'b1000;
    tick();
    int_in = 4'b0000;
    tick();
    checks++; if (vector !== 10'd1012) begin errors++; $display("FAIL stable_vector0: got %0d exp 1012", vector); end
    int_in = 4'b0001; mask_we = 1'b1; mask_din = 4'b1111;
    tick();
    int_in = 4'b0000; mask_we = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL stable_irq: got %b exp 1", irq); end
    checks++; if (vector !== 10'd1012) begin errors++; $display("FAIL stable_vector: got %0d exp 1012", vector); end
    checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL stable_pending: got %b exp 1001", pending); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (in_service !== 4'b1000) begin errors++; $display("FAIL stable_in_service: got %b exp 1000", in_service); end
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL stable_masked_irq: got %b exp 0", irq); end
    set_mask(4'b0000);
    tick();
    checks++; if (vector !== 10'd1000 || irq !== 1'b1) begin errors++; $display("FAIL stable_retained: got irq %b vec %0d exp 1 1000", irq, vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  task automatic test_nesting;
    int_in = 4'b0100; tick(); int_in = 4'b0000; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL nest_serv2: got %b exp 0100", in_service); end
    int_in = 4'b0001; tick(); int_in = 4'b0000;
    tick();
`ifdef IC_NESTING_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL nest_irq: got %b exp 1", irq); end
    checks++; if (vector !== 10'd1000) begin errors++; $display("FAIL nest_vector: got %0d exp 1000", vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (in_service !== 4'b0101) begin errors++; $display("FAIL nest_in_service: got %b exp 0101", in_service); end
    iret = 1'b1; tick();
    checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL nest_iret1: got %b exp 0100", in_service); end
    tick(); iret = 1'b0;
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL nest_iret2: got %b exp 0000", in_service); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nest_idle: got %b exp 0", irq); end
`else
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nonest_irq: got %b exp 0", irq); end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL nonest_iret: got %b exp 0000", in_service); end
    tick();
    checks++; if (irq !== 1'b1 || vector !== 10'd1000) begin errors++; $display("FAIL nonest_after: got irq %b vec %0d exp 1 1000", irq, vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL nonest_done: got %b exp 0000", in_service); end
`endif
  endtask

  task automatic test_ignore;
    irq_ack = 1'b1; iret = 1'b1; tick(); irq_ack = 1'b0; iret = 1'b0;
    checks++; if (irq !== 1'b0 || in_service !== 4'b0000) begin errors++; $display("FAIL ign_idle: got irq %b isr %b exp 0 0000", irq, in_service); end
    int_in = 4'b0100; tick(); int_in = 4'b0000; tick();
    irq_ack = 1'b1; iret = 1'b1; tick(); irq_ack = 1'b0; iret = 1'b0;
    checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL ign_both: got %b exp 0100", in_service); end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (in_service !== 4'b0000) begin errors++; $display("FAIL ign_iret: got %b exp 0000", in_service); end
  endtask

  task automatic test_reset_mid;
    int_in = 4'b0010; tick(); int_in = 4'b0000; tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b exp 1", irq); end
    reset = 1'b1; tick();
    checks++; if (irq !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL rmid_clear: got irq %b pend %b exp 0 0000", irq, pending); end
    checks++; if (mask !== 4'b1111 || vector !== 10'd0) begin errors++; $display("FAIL rmid_mask: got mask %b vec %0d exp 1111 0", mask, vector); end
    int_in = 4'b0010; tick();
    reset = 1'b0; tick();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL rmid_held: got %b exp 0010", pending); end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_masked: got %b exp 0", irq); end
    int_in = 4'b0000;
  endtask

  task automatic test_hold;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    set_mask(4'b0000);
    int_in = 4'b0010;
    tick(10);
    checks++; if (pending !== 4'b0010 || irq !== 1'b1) begin errors++; $display("FAIL hold_one: got pend %b irq %b exp 0010 1", pending, irq); end
    checks++; if (vector !== 10'd1004) begin errors++; $display("FAIL hold_vector: got %0d exp 1004", vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tick(2);
    checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL hold_noretrig: got pend %b irq %b exp 0000 0", pending, irq); end
    int_in = 4'b0000;
    iret = 1'b1; tick(); iret = 1'b0;
    int_in = 4'b0010; tick(); int_in = 4'b0000; tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL hold_req2: got %b exp 1", irq); end
    int_in = 4'b0010; irq_ack = 1'b1; tick(); irq_ack = 1'b0; int_in = 4'b0000;
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL hold_edge_wins: got %b exp 0010", pending); end
    checks++; if (in_service !== 4'b0010) begin errors++; $display("FAIL hold_edge_isr: got %b exp 0010", in_service); end
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    checks++; if (irq !== 1'b1 || vector !== 10'd1004) begin errors++; $display("FAIL hold_rearm: got irq %b vec %0d exp 1 1004", irq, vector); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (in_service !== 4'b0000 || pending !== 4'b0000) begin errors++; $display("FAIL hold_done: got isr %b pend %b exp 0000 0000", in_service, pending); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_stable();
    test_nesting();
    test_ignore();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
